// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
// Loads a packed-BCD HH:MM:SS preset and counts it down once per second.
// A second is CLK_DIV clock cycles. The counter flags expiry with a level
// (done) and a one-cycle pulse (done_pulse).
//
// Optional feature: define ALARM_TIMEOUT_EN to make DONE clear itself.
// After ALARM_SECS further seconds the state returns to IDLE. Without the
// macro, DONE holds until a valid load or reset, and ALARM_SECS is unused.
module bcd_countdown_timer #(
  parameter int CLK_DIV    = 100000000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] h_in,
  input  logic [7:0] m_in,
  input  logic [7:0] s_in,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] h_out,
  output logic [7:0] m_out,
  output logic [7:0] s_out,
  output logic       running,
  output logic       done,
  output logic       done_pulse,
  output logic       load_err
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAUSED = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [23:0]   time_reg;        // {hours, minutes, seconds}, packed BCD
  logic          done_pulse_reg;
  logic          load_err_reg;

  logic          load_ok;
  logic          tick;
  logic [23:0]   dec_value;
  logic [5:0]    borrow;

  // A preset is accepted only if every digit is legal BCD for its field.
  assign load_ok = (s_in[3:0] <= 4'd9) && (s_in[7:4] <= 4'd5) &&
                   (m_in[3:0] <= 4'd9) && (m_in[7:4] <= 4'd5) &&
                   (h_in[3:0] <= 4'd9) && (h_in <= 8'h23);

  assign tick = (presc_reg == PW'(CLK_DIV - 1));

  // Digit-wise BCD decrement, least-significant digit first.
  // The seconds units digit always takes the borrow. Each digit that
  // underflows wraps to its field maximum: 9 for units, 5 for minute and
  // second tens. Hours units also wrap to 9, so 10 -> 09 and 20 -> 19.
  // The hours tens digit never underflows because the value is non-zero
  // whenever a tick is applied.
  assign borrow[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      localparam logic [3:0] WRAP = (gi == 1 || gi == 3) ? 4'd5 : 4'd9;
      logic [3:0] digit;
      assign digit = time_reg[gi*4 +: 4];
      assign dec_value[gi*4 +: 4] = !borrow[gi]      ? digit :
                                    (digit == 4'd0)  ? WRAP  :
                                                       digit - 4'd1;
      if (gi < 5) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & (digit == 4'd0);
      end
    end
  endgenerate

`ifdef ALARM_TIMEOUT_EN
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
  logic [AW-1:0] alarm_cnt_reg;
`else
  // ALARM_SECS only sizes the alarm counter, which this build omits.
  if (ALARM_SECS < 0) begin : g_alarm_unused
  end
`endif

  // Main FSM. Within one cycle, load wins over stop, and stop wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      presc_reg      <= '0;
      time_reg       <= '0;
      done_pulse_reg <= 1'b0;
      load_err_reg   <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
      alarm_cnt_reg  <= '0;
`endif
    end else begin
      done_pulse_reg <= 1'b0;
      load_err_reg   <= 1'b0;
      if (load) begin
        // A rejected preset freezes everything for this cycle except the error pulse.
        if (load_ok) begin
          time_reg  <= {h_in, m_in, s_in};
          state_reg <= PAUSED;
          presc_reg <= '0;
`ifdef ALARM_TIMEOUT_EN
          alarm_cnt_reg <= '0;
`endif
        end else begin
          load_err_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          IDLE: begin
          end
          PAUSED: begin
            // A zero preset cannot be started.
            if (start && !stop && (|time_reg)) begin
              state_reg <= RUN;
              presc_reg <= '0;
            end
          end
          RUN: begin
            if (stop) begin
              // The prescaler keeps its count until the next start clears it.
              state_reg <= PAUSED;
            end else if (tick) begin
              presc_reg <= '0;
              time_reg  <= dec_value;
              if (dec_value == 24'h000000) begin
                state_reg      <= DONE;
                done_pulse_reg <= 1'b1;
`ifdef ALARM_TIMEOUT_EN
                alarm_cnt_reg  <= '0;
`endif
              end
            end else begin
              presc_reg <= presc_reg + PW'(1);
            end
          end
          DONE: begin
`ifdef ALARM_TIMEOUT_EN
            // Seconds keep ticking while the alarm sounds. The display stays at 00:00:00.
            if (tick) begin
              presc_reg <= '0;
              if (alarm_cnt_reg == AW'(ALARM_SECS - 1)) begin
                state_reg     <= IDLE;
                alarm_cnt_reg <= '0;
              end else begin
                alarm_cnt_reg <= alarm_cnt_reg + AW'(1);
              end
            end else begin
              presc_reg <= presc_reg + PW'(1);
            end
`endif
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign h_out      = time_reg[23:16];
  assign m_out      = time_reg[15:8];
  assign s_out      = time_reg[7:0];
  assign running    = (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign done_pulse = done_pulse_reg;
  assign load_err   = load_err_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed testbench for bcd_countdown_timer (CLK_DIV=4, ALARM_SECS=2).
// Expected values are queued when stimulus is applied and popped at each check.
module tb_bcd_countdown_timer;

  localparam int CLK_DIV    = 4;
  localparam int ALARM_SECS = 2;

  logic       clk;
  logic       reset;
  logic       load;
  logic       start;
  logic       stop;
  logic [7:0] h_in, m_in, s_in;
  logic [7:0] h_out, m_out, s_out;
  logic       running, done, done_pulse, load_err;

  bcd_countdown_timer #(.CLK_DIV(CLK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .h_in       (h_in),
    .m_in       (m_in),
    .s_in       (s_in),
    .start      (start),
    .stop       (stop),
    .h_out      (h_out),
    .m_out      (m_out),
    .s_out      (s_out),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Flag word layout: {running, done, done_pulse, load_err}
  function automatic logic [31:0] tval();
    return {8'h00, h_out, m_out, s_out};
  endfunction

  function automatic logic [31:0] flags();
    return {28'h0, running, done, done_pulse, load_err};
  endfunction

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h required=queued_entry", obs);
    end else begin
      e = sb_q.pop_front();
      $display("check %-14s observed=%h expected=%h", e.tag, obs, e.exp);
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(negedge clk);
    load = 1'b1; h_in = h; m_in = m; s_in = s;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    logic [23:0] bad [4];
    bad[0] = 24'h240000;
    bad[1] = 24'h005A00;
    bad[2] = 24'h000060;
    bad[3] = 24'h1A0000;

    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    h_in = 8'h00; m_in = 8'h00; s_in = 8'h00;

    // Reset state
    wait_cycles(3);
    push("rst_time", 32'h0);
    push("rst_flags", 32'h0);
    check(tval());
    check(flags());
    reset = 1'b0;

    // Basic countdown 00:00:03 with expiry
    do_load(8'h00, 8'h00, 8'h03);
    push("t1_load", 32'h000003);
    push("t1_load_flg", 32'h0);
    check(tval());
    check(flags());
    do_start();
    push("t1_s_c3", 32'h000003);
    push("t1_s_c4", 32'h000002);
    push("t1_flg_c4", 32'h8);
    push("t1_s_c8", 32'h000001);
    push("t1_s_c12", 32'h000000);
    push("t1_flg_c12", 32'h6);
    push("t1_flg_c13", 32'h4);
    wait_cycles(3);  check(tval());
    wait_cycles(1);  check(tval()); check(flags());
    wait_cycles(4);  check(tval());
    wait_cycles(4);  check(tval()); check(flags());
    wait_cycles(1);  check(flags());

    // Borrow chains
    do_load(8'h01, 8'h00, 8'h00); do_start();
    push("t2_01h", 32'h005959);
    wait_cycles(4); check(tval());
    do_load(8'h20, 8'h00, 8'h00); do_start();
    push("t2_20h", 32'h195959);
    wait_cycles(4); check(tval());
    do_load(8'h00, 8'h10, 8'h00); do_start();
    push("t2_10m", 32'h000959);
    wait_cycles(4); check(tval());
    do_load(8'h10, 8'h00, 8'h00); do_start();
    push("t2_10h", 32'h095959);
    wait_cycles(4); check(tval());
    do_stop();
    push("t2_stop_flg", 32'h0);
    check(flags());

    // Rejected presets while paused at 09:59:59
    for (int i = 0; i < 4; i++) begin
      do_load(bad[i][23:16], bad[i][15:8], bad[i][7:0]);
      push($sformatf("t3_err%0d", i), 32'h1);
      push($sformatf("t3_keep%0d", i), 32'h095959);
      push($sformatf("t3_clr%0d", i), 32'h0);
      check(flags());
      check(tval());
      wait_cycles(1);
      check(flags());
    end

    // Pause and resume
    do_load(8'h00, 8'h00, 8'h10);
    do_start();
    wait_cycles(1);
    do_stop();
    push("t4_paused", 32'h000010);
    push("t4_pause_flg", 32'h0);
    wait_cycles(20);
    check(tval());
    check(flags());
    do_start();
    push("t4_rs_c3", 32'h000010);
    push("t4_rs_c4", 32'h000009);
    wait_cycles(3); check(tval());
    wait_cycles(1); check(tval());

    // Zero preset cannot start; start+stop together while paused
    do_load(8'h00, 8'h00, 8'h00);
    do_start();
    push("t5_zero_flg", 32'h0);
    push("t5_zero_t", 32'h0);
    wait_cycles(2);
    check(flags());
    check(tval());
    do_load(8'h00, 8'h00, 8'h05);
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    push("t5_ss_t", 32'h000005);
    push("t5_ss_flg", 32'h0);
    wait_cycles(8);
    check(tval());
    check(flags());

    // DONE persistence or alarm timeout
    do_load(8'h00, 8'h00, 8'h01);
    do_start();
    push("t6_done", 32'h6);
    wait_cycles(4); check(flags());
`ifdef ALARM_TIMEOUT_EN
    push("t6_alarm_c7", 32'h4);
    push("t6_alarm_c8", 32'h0);
    push("t6_alarm_t", 32'h0);
    wait_cycles(7); check(flags());
    wait_cycles(1); check(flags()); check(tval());
`else
    push("t6_hold100", 32'h4);
    push("t6_start_ign", 32'h4);
    wait_cycles(100); check(flags());
    do_start();
    wait_cycles(6); check(flags());
`endif
    do_load(8'h00, 8'h00, 8'h02);
    push("t6_reload_t", 32'h000002);
    push("t6_reload_f", 32'h0);
    check(tval());
    check(flags());

    // Reset mid-RUN
    do_start();
    wait_cycles(2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push("t7_rst_t", 32'h0);
    push("t7_rst_f", 32'h0);
    check(tval());
    check(flags());
    do_load(8'h00, 8'h00, 8'h02);
    do_start();
    push("t7_after_c4", 32'h000001);
    wait_cycles(4); check(tval());

    n_assert++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d required=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Countdown engine that consumes the BCD HH:MM:SS preset produced by the chronometer setup/edit stage. It loads the preset, counts down once per second from an internal prescaler, and flags expiry. Its outputs drive the display mux and the alarm/buzzer logic.

Parameters:
CLK_DIV, 100000000, clk cycles per one-second tick; minimum 2.
ALARM_SECS, 10, seconds done stays asserted before auto-clear (only used with the optional feature).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle pulse; capture h_in/m_in/s_in
h_in  input  8  preset hours, packed BCD {tens,units}, 00..23
m_in  input  8  preset minutes, packed BCD, 00..59
s_in  input  8  preset seconds, packed BCD, 00..59
start  input  1  one-cycle pulse; begin/resume countdown
stop  input  1  one-cycle pulse; pause countdown
h_out  output  8  current hours, packed BCD
m_out  output  8  current minutes, packed BCD
s_out  output  8  current seconds, packed BCD
running  output  1  high in RUN state
done  output  1  level; high in DONE state
done_pulse  output  1  one-cycle pulse on entry to DONE
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset: state=IDLE; h_out/m_out/s_out=8'h00; running=0; done=0; done_pulse=0; load_err=0; prescaler=0.
- States: IDLE, PAUSED, RUN, DONE. running = (state==RUN); done = (state==DONE).
- Load validation: the unit digit of each field must be <=9. Minutes and seconds tens must be <=5. Hours must be <=8'h23.
- Valid load, any state: registers take the inputs on the next edge; state->PAUSED; prescaler cleared.
- Invalid load: registers and state are unchanged; load_err pulses 1 cycle later.
- Priority within one cycle: load > stop > start.
- PAUSED + start: if the value is 00:00:00, start is ignored; otherwise state->RUN and the prescaler is cleared.
- RUN + stop: state->PAUSED. The prescaler holds its count, and a later start clears it.
- Start in RUN or DONE is ignored. Start in IDLE is ignored. Stop outside RUN is ignored.
- Prescaler: counts 0..CLK_DIV-1 while in RUN. The tick fires in the cycle the count equals CLK_DIV-1, then the count wraps to 0. The first decrement therefore occurs CLK_DIV cycles after start is sampled.
- Decrement on tick, all arithmetic digit-wise BCD with borrow chain:
  - s units 0 -> 9 with borrow; s 00 -> 59 with borrow into minutes.
  - m 00 -> 59 with borrow into hours.
  - h decrements only on borrow.
  - Hours 10 -> 09, 20 -> 19.
- Expiry: the tick that takes 00:00:01 to 00:00:00 moves state->DONE in the same edge. done_pulse is high for exactly that following cycle. Outputs hold 00:00:00.
- DONE exits only via a valid load (->PAUSED) or reset. With the optional feature, DONE also times out (see below).
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro ALARM_TIMEOUT_EN.
- Defined: in DONE, the prescaler keeps running. After ALARM_SECS ticks, state->IDLE, done drops, and outputs stay at 00:00:00.
- Not defined: DONE persists until a valid load or reset, and ALARM_SECS is unused.

Test Plan:
- CLK_DIV=4. Load 00:00:03, then start. Expected: s_out reads 02, 01, 00 at 4, 8 and 12 cycles after start. done rises at the 00 step, and done_pulse is high for 1 cycle.
- Load 01:00:00, then start, then wait 1 tick. Expected: 00:59:59. Also load 20:00:00 and tick once. Expected: 19:59:59.
- Load h_in=8'h24, or m_in=8'h5A, or s_in=8'h60. Expected: load_err pulses once, outputs unchanged, state unchanged.
- Load 00:00:10, start, then stop after 2 cycles, hold 20 cycles, then start. Expected: no decrement while paused; the next decrement comes 4 cycles after the restart.
- Load 00:00:00, then start. Expected: stays PAUSED, running=0, done=0. Also assert start and stop in the same cycle while PAUSED. Expected: stop wins, state stays PAUSED.
- ALARM_TIMEOUT_EN defined, ALARM_SECS=2, CLK_DIV=4, done reached. Expected: done falls after 8 cycles and state is IDLE. Without the macro, done is still 1 after 100 cycles, and reset mid-RUN returns all outputs to 0.
